// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word requests into aligned 32-bit
// memory cycles, with sign/zero extension and read-modify-write for SB/SH.
module load_store_unit #(
  parameter int HEIGHT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        f3_ok, misal, oor, req_err;
  logic [31:0] lane, load_val, merged;

  always_comb begin
    f3_ok = i_we ? (i_funct3 inside {3'b000, 3'b001, 3'b010})
                 : (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00) ||
            (i_funct3[1:0] == 2'b01 && i_addr[0]);
    oor     = i_addr >= 32'(HEIGHT);
    req_err = !f3_ok || misal || oor;
  end

  always_comb begin
    lane = i_mem_rd >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // Only aligned offsets reach CAPT, so SH always lands on lanes 0-1 or 2-3.
  always_comb begin
    merged = i_mem_rd;
    if (f3_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      o_rdata    <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_busy     <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wd   <= '0;
      o_mem_wen  <= 1'b0;
      o_mem_ren  <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_mem_ren <= 1'b0;
      o_mem_wen <= 1'b0;
      case (state)
        IDLE: if (i_req) begin
          if (req_err) begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
          end else begin
            we_q       <= i_we;
            f3_q       <= i_funct3;
            off_q      <= i_addr[1:0];
            wdata_q    <= i_wdata[15:0];
            o_mem_addr <= {i_addr[31:2], 2'b00};
            o_busy     <= 1'b1;
            if (i_we && i_funct3 == 3'b010) begin
              o_mem_wd  <= i_wdata;
              o_mem_wen <= 1'b1;
              state     <= WRITE;
            end else begin
              o_mem_ren <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: state <= CAPT;
        CAPT: if (we_q) begin
          o_mem_wd  <= merged;
          o_mem_wen <= 1'b1;
          state     <= WRITE;
        end else begin
          o_rdata <= load_val;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        WRITE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model checked every
// cycle, plus directed literal cases and randomized traffic.
module tb_load_store_unit;
  localparam int HEIGHT = 256;

  logic        clk = 1'b0, rst = 1'b1, init = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wd, mem_rd;
  logic        o_done, o_err, o_busy, o_mem_wen, o_mem_ren;

  logic [31:0] mem [64];
  logic [31:0] ref_m [64];
  int checks = 0, errors = 0;
  int ren_cnt = 0, wen_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.HEIGHT(HEIGHT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(o_rdata), .o_done(o_done),
    .o_err(o_err), .o_busy(o_busy), .o_mem_addr(o_mem_addr),
    .o_mem_wd(o_mem_wd), .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren),
    .i_mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8899AABB : 32'(i) * 32'h9E3779B9;
  endfunction

  // Data memory: registered read, write on the rising edge.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else begin
      if (o_mem_wen) mem[o_mem_addr[7:2]] <= o_mem_wd;
      if (o_mem_ren) mem_rd <= mem[o_mem_addr[7:2]];
    end
    if (o_mem_ren) ren_cnt <= ren_cnt + 1;
    if (o_mem_wen) wen_cnt <= wen_cnt + 1;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic bit is_err(input bit w, input logic [2:0] f, input logic [31:0] a);
    bit legal, mis;
    legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    mis   = (f[1:0] == 2'd2 && a[1:0] != 2'd0) || (f[1:0] == 2'd1 && a[0]);
    return !legal || mis || a >= 32'(HEIGHT);
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] f, input logic [1:0] off);
    logic [31:0] l;
    l = w >> (8 * off);
    case (f)
      3'd0: return 32'($signed(l[7:0]));
      3'd1: return 32'($signed(l[15:0]));
      3'd4: return l & 32'hFF;
      3'd5: return l & 32'hFFFF;
      default: return l;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    if (f == 3'd2) return d;
    mask = (f == 3'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
  endfunction

  // Reference model: one transaction at a time, tracked by cycles since accept.
  bit          act = 0, m_we = 0, m_err = 0, was_rst = 0;
  int          t = 0, lat = 0, wen_t = 0, ren_t = 0;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    if (init) for (int i = 0; i < 64; i++) ref_m[i] = init_word(i);
    if (act && t == wen_t)
      ref_m[m_addr[7:2]] = st_merge(ref_m[m_addr[7:2]], m_f3, m_addr[1:0], m_wdata);
    was_rst = rst;
    if (rst) begin
      act = 0;
      m_rdata = '0;
    end else begin
      if (act && !m_err && !m_we && t == lat - 1)
        m_rdata = ld_ext(ref_m[m_addr[7:2]], m_f3, m_addr[1:0]);
      if (act && t == lat) act = 0;
      if (act) t++;
      else if (req) begin
        m_we = we; m_f3 = f3; m_addr = addr; m_wdata = wdata;
        m_err = is_err(we, f3, addr);
        lat   = m_err ? 1 : (we && f3 == 3'd2) ? 2 : we ? 4 : 3;
        wen_t = (m_err || !we) ? 0 : (f3 == 3'd2) ? 1 : 3;
        ren_t = (m_err || (we && f3 == 3'd2)) ? 0 : 1;
        act = 1;
        t = 1;
      end
    end
    #1;
    chk("done",  32'(o_done),    32'(act && t == lat));
    chk("err",   32'(o_err),     32'(act && t == lat && m_err));
    chk("busy",  32'(o_busy),    32'(act && t < lat));
    chk("ren",   32'(o_mem_ren), 32'(act && t == ren_t));
    chk("wen",   32'(o_mem_wen), 32'(act && t == wen_t));
    chk("rdata", o_rdata, m_rdata);
    if (act && !m_err) chk("mem_addr", o_mem_addr, {m_addr[31:2], 2'b00});
    if (act && t == wen_t)
      chk("mem_wd", o_mem_wd, st_merge(ref_m[m_addr[7:2]], m_f3, m_addr[1:0], m_wdata));
    if (was_rst) begin
      chk("rst_addr", o_mem_addr, 32'd0);
      chk("rst_wd",   o_mem_wd,   32'd0);
    end
  end

  // Issue one request from a negedge; returns at the negedge of the done cycle
  // (lat_seen = latency), after an injected reset (0), or on timeout (-1).
  task automatic op(input bit w, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] d, input bit hold, input int rst_at,
                    output int lat_seen);
    bit fin = 0;
    we = w; f3 = f; addr = a; wdata = d; req = 1'b1;
    lat_seen = -1;
    for (int i = 1; i <= 8 && !fin; i++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (i == 1) begin addr = $urandom; wdata = $urandom; end
      if (o_done) begin
        req = 1'b0; lat_seen = i; fin = 1;
      end else if (i == rst_at) begin
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; lat_seen = 0; fin = 1;
      end
    end
    req = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout waiting for done at %0t", $time);
    end
  endtask

  task automatic dir(input string n, input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input int exp_ren, input int exp_wen);
    int l, r0, w0;
    r0 = ren_cnt; w0 = wen_cnt;
    op(w, f, a, d, 1'b0, 0, l);
    chk({n, "_lat"}, 32'(l), 32'(exp_lat));
    chk({n, "_ren"}, 32'(ren_cnt - r0), 32'(exp_ren));
    chk({n, "_wen"}, 32'(wen_cnt - w0), 32'(exp_wen));
  endtask

  initial begin
    int l, r0, w0;
    logic [31:0] keep;
    repeat (2) @(negedge clk);
    init = 1'b0; rst = 1'b0;
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);

    dir("LB",  0, 3'b000, 32'h11, 0, 3, 1, 0); chk("LB_val",  o_rdata, 32'hFFFFFFAA);
    dir("LBU", 0, 3'b100, 32'h13, 0, 3, 1, 0); chk("LBU_val", o_rdata, 32'h00000088);
    dir("LH",  0, 3'b001, 32'h12, 0, 3, 1, 0); chk("LH_val",  o_rdata, 32'hFFFF8899);
    dir("LHU", 0, 3'b101, 32'h10, 0, 3, 1, 0); chk("LHU_val", o_rdata, 32'h0000AABB);
    dir("LW",  0, 3'b010, 32'h10, 0, 3, 1, 0); chk("LW_val",  o_rdata, 32'h8899AABB);
    chk("LW_err", 32'(o_err), 32'd0);

    dir("SB", 1, 3'b000, 32'h12, 32'h123456CC, 4, 1, 1); chk("SB_mem", mem[4], 32'h88CCAABB);
    dir("SH", 1, 3'b001, 32'h10, 32'hFFFF1234, 4, 1, 1); chk("SH_mem", mem[4], 32'h88CC1234);
    dir("SW", 1, 3'b010, 32'h20, 32'hDEADBEEF, 2, 0, 1);
    dir("LW20", 0, 3'b010, 32'h20, 0, 3, 1, 0); chk("LW20_val", o_rdata, 32'hDEADBEEF);

    dir("E_LW",  0, 3'b010, 32'h12,  0, 1, 0, 0); chk("E_LW_err", 32'(o_err), 32'd1);
    dir("E_SH",  1, 3'b001, 32'h11,  0, 1, 0, 0); chk("E_SH_err", 32'(o_err), 32'd1);
    dir("E_F3",  0, 3'b011, 32'h10,  0, 1, 0, 0); chk("E_F3_err", 32'(o_err), 32'd1);
    dir("E_OOR", 0, 3'b000, 32'h100, 0, 1, 0, 0); chk("E_OOR_err", 32'(o_err), 32'd1);
    chk("E_rdata_kept", o_rdata, 32'hDEADBEEF);

    // Reset while the SB sits in its capture cycle.
    w0 = wen_cnt;
    op(1, 3'b000, 32'h12, 32'h000000EE, 1'b0, 2, l);
    chk("RST_ret", 32'(l), 32'd0);
    chk("RST_rdata", o_rdata, 32'd0);
    repeat (3) @(negedge clk);
    chk("RST_wen", 32'(wen_cnt - w0), 32'd0);
    chk("RST_mem", mem[4], 32'h88CC1234);
    dir("LW_after", 0, 3'b010, 32'h10, 0, 3, 1, 0); chk("LW_after_val", o_rdata, 32'h88CC1234);

    // Request held high while busy, then back-to-back issue on done.
    r0 = ren_cnt;
    op(0, 3'b010, 32'h20, 0, 1'b1, 0, l);
    chk("HOLD_lat", 32'(l), 32'd3);
    chk("HOLD_ren", 32'(ren_cnt - r0), 32'd1);
    op(0, 3'b010, 32'h10, 0, 1'b0, 0, l);
    chk("B2B_lat", 32'(l), 32'd3);
    chk("B2B_val", o_rdata, 32'h88CC1234);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int ra;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, HEIGHT + 8));
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
      keep = 32'($urandom_range(0, 7));
      op(1'($urandom_range(0, 1)), keep[2:0], a, $urandom, 1'($urandom_range(0, 1)), ra, l);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_m[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
